mfp_adc_max10_arbiter: RTL and testbench

//  Shares one MAX10 ADC (Avalon-ST command/response) between N_REQ single-sample requesters
//  (CPU register block, trigger sequencer, DMA, etc.). Round-robin grant, one conversion in

---
 rtl/mfp_adc_max10_arbiter_pkg.sv | 33 +++
 rtl/mfp_adc_max10_arbiter_rr.sv | 40 ++++
 rtl/mfp_adc_max10_arbiter.sv | 152 +++++++++++++++
 tb/tb_mfp_adc_max10_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_adc_max10_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mfp_adc_max10_arbiter_pkg
//   Shared definitions for the MAX10 ADC arbiter slice: ADC channel codes,
//   default widths, FSM state encoding and the legal-channel helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package mfp_adc_max10_arbiter_pkg;

    localparam int ADC_CHAN_WIDTH = 5;
    localparam int ADC_DATA_WIDTH = 12;

    // Channel codes accepted by the MAX10 ADC sequencer.
    localparam int ADC_CH_1 = 1;
    localparam int ADC_CH_2 = 2;
    localparam int ADC_CH_3 = 3;
    localparam int ADC_CH_4 = 4;
    localparam int ADC_CH_5 = 5;
    localparam int ADC_CH_6 = 6;
    localparam int ADC_CH_T = 17;   // on-die temperature sensor

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMD  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // True for channel codes the ADC can actually convert.
    function automatic logic chan_legal(input int unsigned ch);
        return ((ch >= ADC_CH_1) && (ch <= ADC_CH_6)) || (ch == ADC_CH_T);
    endfunction

endpackage

// File: rtl/mfp_adc_max10_arbiter_rr.sv
// ---------------------------------------------------------------------------
// mfp_adc_max10_arbiter_rr
//   Combinational round-robin pick. Searches req starting one position after
//   last_grant, wrapping modulo N_REQ, and returns the first set bit.
// Ports
//   req        in   N_REQ   request vector
//   last_grant in   IDX_W   index granted most recently
//   grant      out  N_REQ   one-hot grant (all zero when no request)
//   index      out  IDX_W   binary index of grant
//   any        out  1       at least one request present
// ---------------------------------------------------------------------------
module mfp_adc_max10_arbiter_rr #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index,
    output logic             any
);

    always_comb begin
        int cand;
        grant = '0;
        index = '0;
        any   = 1'b0;
        cand  = 0;
        // Offsets 1..N_REQ so the last winner is considered last.
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_grant) + k) % N_REQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                index       = IDX_W'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mfp_adc_max10_arbiter.sv
// ---------------------------------------------------------------------------
// mfp_adc_max10_arbiter
//   Shares one MAX10 ADC (Avalon-ST command/response) between N_REQ
//   single-sample requesters. Round-robin grant, one conversion in flight,
//   result routed back to the granted requester, timeout on lost responses.
//
// Handshakes: a requester holds REQ_Valid and its channel until it sees its
//   REQ_Ready bit (combinational, only in S_IDLE). The command is held stable
//   with ADC_C_Valid=1 until ADC_C_Ready is sampled high. ADC responses carry
//   no back-pressure; they are only looked at in S_WAIT. RSP_Valid is a
//   one-cycle strobe with no ready.
//
// Ports
//   CLK, RESETn                    clock, async active-low reset
//   REQ_Valid/REQ_Channel          per-requester request and channel code
//   REQ_Ready                      one-hot accept strobe
//   RSP_Valid/RSP_Data/RSP_Error   one-hot result strobe, sample, error flag
//   ADC_C_*                        ADC command stream
//   ADC_R_*                        ADC response stream
//   DBG_State                      current FSM state (state_t encoding)
// ---------------------------------------------------------------------------
module mfp_adc_max10_arbiter
    import mfp_adc_max10_arbiter_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int TIMEOUT    = 1024,
    parameter int CH_WIDTH   = ADC_CHAN_WIDTH,
    parameter int DATA_WIDTH = ADC_DATA_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RESETn,
    input  logic [N_REQ-1:0]          REQ_Valid,
    input  logic [N_REQ*CH_WIDTH-1:0] REQ_Channel,
    output logic [N_REQ-1:0]          REQ_Ready,
    output logic [N_REQ-1:0]          RSP_Valid,
    output logic [DATA_WIDTH-1:0]     RSP_Data,
    output logic                      RSP_Error,
    output logic                      ADC_C_Valid,
    output logic [CH_WIDTH-1:0]       ADC_C_Channel,
    output logic                      ADC_C_SOP,
    output logic                      ADC_C_EOP,
    input  logic                      ADC_C_Ready,
    input  logic                      ADC_R_Valid,
    input  logic [CH_WIDTH-1:0]       ADC_R_Channel,
    input  logic [DATA_WIDTH-1:0]     ADC_R_Data,
    output logic [1:0]                DBG_State
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [N_REQ-1:0] REQ_ONE = N_REQ'(1);

    state_t              state;
    logic [IDX_W-1:0]    last_grant;
    logic [IDX_W-1:0]    grant_q;
    logic [CH_WIDTH-1:0] chan_q;
    logic [TMR_W-1:0]    timer;

    logic [N_REQ-1:0]    grant_oh;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_any;
    logic [CH_WIDTH-1:0] req_chan;
    logic                rsp_match;

    mfp_adc_max10_arbiter_rr #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req        (REQ_Valid),
        .last_grant (last_grant),
        .grant      (grant_oh),
        .index      (grant_idx),
        .any        (grant_any)
    );

    assign req_chan  = REQ_Channel[grant_idx*CH_WIDTH +: CH_WIDTH];
    assign rsp_match = ADC_R_Valid && (ADC_R_Channel == chan_q);

    // Accept is the only combinational output: the requester sees it in the
    // same cycle the arbiter decides.
    assign REQ_Ready     = (state == S_IDLE) ? grant_oh : '0;
    assign ADC_C_Channel = chan_q;
    assign ADC_C_SOP     = ADC_C_Valid;   // single-beat packets
    assign ADC_C_EOP     = ADC_C_Valid;
    assign DBG_State     = state;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state       <= S_IDLE;
            last_grant  <= IDX_W'(N_REQ - 1);   // requester 0 wins first
            grant_q     <= '0;
            chan_q      <= '0;
            timer       <= '0;
            ADC_C_Valid <= 1'b0;
            RSP_Valid   <= '0;
            RSP_Data    <= '0;
            RSP_Error   <= 1'b0;
        end else begin
            RSP_Valid <= '0;
            case (state)
                S_IDLE: begin
                    if (grant_any) begin
                        grant_q    <= grant_idx;
                        last_grant <= grant_idx;
                        chan_q     <= req_chan;
                        if (chan_legal(32'(req_chan))) begin
                            ADC_C_Valid <= 1'b1;
                            state       <= S_CMD;
                        end else begin
                            // Never reaches the ADC; answered directly.
                            RSP_Error <= 1'b1;
                            RSP_Data  <= '0;
                            RSP_Valid <= grant_oh;
                            state     <= S_RESP;
                        end
                    end
                end
                S_CMD: begin
                    if (ADC_C_Ready) begin
                        ADC_C_Valid <= 1'b0;
                        timer       <= '0;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Match is tested first so a response on the expiry
                    // cycle is still delivered without error.
                    if (rsp_match) begin
                        RSP_Data  <= ADC_R_Data;
                        RSP_Error <= 1'b0;
                        RSP_Valid <= REQ_ONE << grant_q;
                        state     <= S_RESP;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        RSP_Data  <= '0;
                        RSP_Error <= 1'b1;
                        RSP_Valid <= REQ_ONE << grant_q;
                        state     <= S_RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mfp_adc_max10_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mfp_adc_max10_arbiter
//   Directed bench for mfp_adc_max10_arbiter (N_REQ=4, TIMEOUT=16).
//   Inputs are driven at the falling edge, outputs checked shortly after,
//   so every check sits half a cycle away from the active edge.
// ---------------------------------------------------------------------------
module tb_mfp_adc_max10_arbiter;

    localparam int N_REQ      = 4;
    localparam int TIMEOUT    = 16;
    localparam int CH_WIDTH   = 5;
    localparam int DATA_WIDTH = 12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // ---------------- clock / reset ----------------
    logic CLK;
    logic RESETn;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUT ----------------
    logic [N_REQ-1:0]          REQ_Valid;
    logic [N_REQ*CH_WIDTH-1:0] REQ_Channel;
    logic [N_REQ-1:0]          REQ_Ready;
    logic [N_REQ-1:0]          RSP_Valid;
    logic [DATA_WIDTH-1:0]     RSP_Data;
    logic                      RSP_Error;
    logic                      ADC_C_Valid;
    logic [CH_WIDTH-1:0]       ADC_C_Channel;
    logic                      ADC_C_SOP;
    logic                      ADC_C_EOP;
    logic                      ADC_C_Ready;
    logic                      ADC_R_Valid;
    logic [CH_WIDTH-1:0]       ADC_R_Channel;
    logic [DATA_WIDTH-1:0]     ADC_R_Data;
    logic [1:0]                DBG_State;

    mfp_adc_max10_arbiter #(
        .N_REQ      (N_REQ),
        .TIMEOUT    (TIMEOUT),
        .CH_WIDTH   (CH_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .CLK           (CLK),
        .RESETn        (RESETn),
        .REQ_Valid     (REQ_Valid),
        .REQ_Channel   (REQ_Channel),
        .REQ_Ready     (REQ_Ready),
        .RSP_Valid     (RSP_Valid),
        .RSP_Data      (RSP_Data),
        .RSP_Error     (RSP_Error),
        .ADC_C_Valid   (ADC_C_Valid),
        .ADC_C_Channel (ADC_C_Channel),
        .ADC_C_SOP     (ADC_C_SOP),
        .ADC_C_EOP     (ADC_C_EOP),
        .ADC_C_Ready   (ADC_C_Ready),
        .ADC_R_Valid   (ADC_R_Valid),
        .ADC_R_Channel (ADC_R_Channel),
        .ADC_R_Data    (ADC_R_Data),
        .DBG_State     (DBG_State)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [CH_WIDTH-1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge CLK);
    endtask

    task automatic set_ch(input int idx, input logic [CH_WIDTH-1:0] ch);
        REQ_Channel[idx*CH_WIDTH +: CH_WIDTH] = ch;
    endtask

    task automatic adc_resp(input logic [CH_WIDTH-1:0] ch, input logic [DATA_WIDTH-1:0] d);
        ADC_R_Valid   = 1'b1;
        ADC_R_Channel = ch;
        ADC_R_Data    = d;
    endtask

    task automatic adc_idle();
        ADC_R_Valid   = 1'b0;
        ADC_R_Channel = '0;
        ADC_R_Data    = '0;
    endtask

    task automatic do_reset();
        REQ_Valid = '0;
        RESETn    = 1'b0;
        step();
        step();
        RESETn = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int order[5];
        logic [CH_WIDTH-1:0] chans[4];
        order = '{0, 1, 2, 3, 0};
        chans = '{5'd1, 5'd2, 5'd3, 5'd17};

        RESETn      = 1'b0;
        REQ_Valid   = '0;
        REQ_Channel = '0;
        ADC_C_Ready = 1'b1;
        adc_idle();
        step();
        step();

        // Reset state
        check("rst_req_ready", REQ_Ready, 0);
        check("rst_rsp_valid", RSP_Valid, 0);
        check("rst_rsp_data", RSP_Data, 0);
        check("rst_rsp_error", RSP_Error, 0);
        check("rst_c_valid", ADC_C_Valid, 0);
        check("rst_c_channel", ADC_C_Channel, 0);
        check("rst_c_sop_eop", {ADC_C_SOP, ADC_C_EOP}, 0);
        check("rst_state", DBG_State, ST_IDLE);
        RESETn = 1'b1;
        step();

        // 1: single request, response 4 cycles after accept
        REQ_Valid = 4'b0001;
        set_ch(0, 5'd3);
        #1 check("t1_ready", REQ_Ready, 4'b0001);
        step();
        REQ_Valid = '0;
        #1;
        check("t1_c_valid", ADC_C_Valid, 1);
        check("t1_c_sop_eop", {ADC_C_SOP, ADC_C_EOP}, 2'b11);
        check("t1_c_channel", ADC_C_Channel, 3);
        check("t1_ready_off", REQ_Ready, 0);
        step();
        check("t1_c_single", ADC_C_Valid, 0);
        check("t1_state_wait", DBG_State, ST_WAIT);
        step();
        step();
        adc_resp(5'd3, 12'hABC);
        check("t1_rsp_early", RSP_Valid, 0);
        step();
        adc_idle();
        check("t1_rsp_valid", RSP_Valid, 4'b0001);
        check("t1_rsp_data", RSP_Data, 12'hABC);
        check("t1_rsp_error", RSP_Error, 0);
        step();
        check("t1_rsp_oneshot", RSP_Valid, 0);
        check("t1_state_idle", DBG_State, ST_IDLE);

        // 2: all four requesting, round-robin 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 4; i++) set_ch(i, chans[i]);
        exp_q.push_back(5'd1);
        exp_q.push_back(5'd2);
        exp_q.push_back(5'd3);
        exp_q.push_back(5'd17);
        exp_q.push_back(5'd1);
        REQ_Valid = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            int g;
            g = order[n];
            #1 check("t2_ready", REQ_Ready, 1 << g);
            step();
            check("t2_c_valid", ADC_C_Valid, 1);
            check("t2_c_channel", ADC_C_Channel, exp_q.pop_front());
            step();
            adc_resp(chans[g], 12'h100 + 12'(n));
            step();
            adc_idle();
            check("t2_rsp_valid", RSP_Valid, 1 << g);
            check("t2_rsp_data", RSP_Data, 12'h100 + 12'(n));
            step();
        end
        REQ_Valid = '0;

        // 3: command back-pressure longer than TIMEOUT, no timeout in S_CMD
        ADC_C_Ready = 1'b0;
        REQ_Valid   = 4'b0010;
        set_ch(1, 5'd4);
        #1 check("t3_ready", REQ_Ready, 4'b0010);
        step();
        REQ_Valid = '0;
        for (int i = 0; i < 20; i++) begin
            #1;
            check("t3_c_valid_hold", ADC_C_Valid, 1);
            check("t3_c_chan_hold", ADC_C_Channel, 4);
            check("t3_no_rsp", RSP_Valid, 0);
            if (i < 19) step();
        end
        ADC_C_Ready = 1'b1;
        step();
        check("t3_c_dropped", ADC_C_Valid, 0);
        adc_resp(5'd4, 12'h456);
        step();
        adc_idle();
        check("t3_rsp_valid", RSP_Valid, 4'b0010);
        check("t3_rsp_data", RSP_Data, 12'h456);
        check("t3_rsp_error", RSP_Error, 0);
        step();

        // 4: foreign-channel response is dropped
        REQ_Valid = 4'b0100;
        set_ch(2, 5'd2);
        #1 check("t4_ready", REQ_Ready, 4'b0100);
        step();
        REQ_Valid = '0;
        step();
        adc_resp(5'd5, 12'h777);
        step();
        adc_resp(5'd2, 12'h123);
        check("t4_foreign_ignored", RSP_Valid, 0);
        check("t4_still_wait", DBG_State, ST_WAIT);
        step();
        adc_idle();
        check("t4_rsp_valid", RSP_Valid, 4'b0100);
        check("t4_rsp_data", RSP_Data, 12'h123);
        check("t4_rsp_error", RSP_Error, 0);
        step();

        // 5a: no response -> error 16 cycles after S_WAIT entry
        REQ_Valid = 4'b1000;
        set_ch(3, 5'd6);
        #1 check("t5_ready", REQ_Ready, 4'b1000);
        step();
        REQ_Valid = '0;
        step();
        check("t5_wait_entry", DBG_State, ST_WAIT);
        for (int i = 1; i <= 15; i++) begin
            step();
            check("t5_no_rsp_yet", RSP_Valid, 0);
        end
        step();
        check("t5_to_valid", RSP_Valid, 4'b1000);
        check("t5_to_error", RSP_Error, 1);
        check("t5_to_data", RSP_Data, 0);
        step();
        check("t5_back_idle", DBG_State, ST_IDLE);

        // 5b: match on the expiry cycle wins
        REQ_Valid = 4'b0001;
        set_ch(0, 5'd17);
        #1 check("t5b_ready", REQ_Ready, 4'b0001);
        step();
        REQ_Valid = '0;
        step();
        repeat (15) step();
        adc_resp(5'd17, 12'h5A5);
        step();
        adc_idle();
        check("t5b_rsp_valid", RSP_Valid, 4'b0001);
        check("t5b_rsp_error", RSP_Error, 0);
        check("t5b_rsp_data", RSP_Data, 12'h5A5);
        step();

        // 6a: illegal channel answered without an ADC command
        REQ_Valid = 4'b0010;
        set_ch(1, 5'd9);
        #1 check("t6_ready", REQ_Ready, 4'b0010);
        step();
        REQ_Valid = '0;
        check("t6_no_cmd", ADC_C_Valid, 0);
        check("t6_state_resp", DBG_State, ST_RESP);
        check("t6_rsp_valid", RSP_Valid, 4'b0010);
        check("t6_rsp_error", RSP_Error, 1);
        check("t6_rsp_data", RSP_Data, 0);
        step();
        check("t6_rsp_oneshot", RSP_Valid, 0);

        // 6b: reset in S_CMD drops the command asynchronously
        ADC_C_Ready = 1'b0;
        REQ_Valid   = 4'b0100;
        set_ch(2, 5'd3);
        #1 check("t6b_ready", REQ_Ready, 4'b0100);
        step();
        REQ_Valid = '0;
        check("t6b_c_valid", ADC_C_Valid, 1);
        RESETn = 1'b0;
        #1;
        check("t6b_async_c_valid", ADC_C_Valid, 0);
        check("t6b_async_state", DBG_State, ST_IDLE);
        step();
        RESETn      = 1'b1;
        ADC_C_Ready = 1'b1;

        // 6c: reset in S_WAIT, late response ignored, requester 0 wins again
        REQ_Valid = 4'b0100;
        #1 check("t6c_ready", REQ_Ready, 4'b0100);
        step();
        REQ_Valid = '0;
        step();
        check("t6c_state_wait", DBG_State, ST_WAIT);
        RESETn = 1'b0;
        #1;
        check("t6c_async_state", DBG_State, ST_IDLE);
        check("t6c_async_rsp", RSP_Valid, 0);
        step();
        RESETn = 1'b1;
        adc_resp(5'd3, 12'hBAD);
        step();
        adc_idle();
        check("t6c_late_ignored", RSP_Valid, 0);
        check("t6c_late_state", DBG_State, ST_IDLE);
        check("t6c_late_data", RSP_Data, 0);
        REQ_Valid = 4'b1001;
        set_ch(0, 5'd1);
        #1 check("t6c_rr_restart", REQ_Ready, 4'b0001);
        step();
        REQ_Valid = '0;
        step();
        adc_resp(5'd1, 12'h321);
        step();
        adc_idle();
        check("t6c_rsp_valid", RSP_Valid, 4'b0001);
        check("t6c_rsp_data", RSP_Data, 12'h321);
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
